// File: rtl/als_spi_ctrl_pkg.sv
// Shared types and default timing constants for the ambient-light-sensor SPI sequencer.
package als_pkg;

    localparam int DEF_CLK_DIV       = 12;
    localparam int DEF_SAMPLE_PERIOD = 5000000;
    localparam int DEF_NBITS         = 16;
    localparam int DEF_DATA_LSB      = 4;
    localparam int DEF_QUIET         = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_TAIL,
        S_QUIET
    } als_state_t;

    // Width of a counter that must reach max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int HP_CNT_W = cnt_width(DEF_CLK_DIV, DEF_QUIET);

endpackage

// File: rtl/als_spi_ctrl_if.sv
// Trigger, sensor-pin and result signals of the light-sensor sequencer.
interface als_spi_ctrl_if;
    logic       enable;
    logic       start;
    logic       sdo;
    logic       cs_n;
    logic       sck;
    logic [7:0] data;
    logic       data_valid;
    logic       busy;
    logic       overrun;

    modport master (
        input  enable, start, sdo,
        output cs_n, sck, data, data_valid, busy, overrun
    );

    modport slave (
        output enable, start, sdo,
        input  cs_n, sck, data, data_valid, busy, overrun
    );
endinterface

// File: rtl/als_spi_ctrl_tick_gen.sv
// Free-running period counter; one-cycle tick every PERIOD clocks while enabled.
module als_tick_gen
    import als_pkg::*;
#(
    parameter int PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int              W    = (PERIOD < 2) ? 1 : $clog2(PERIOD);
    localparam logic [W-1:0]    LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !enable)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/als_spi_ctrl.sv
// SPI conversion sequencer for the light-sensor ADC: CS/SCK generation, frame capture, 8-bit result.
// Build option ALS_AVG_EN: output becomes the 4-sample running mean of captured values.
module als_spi_ctrl
    import als_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int NBITS         = DEF_NBITS,
    parameter int DATA_LSB      = DEF_DATA_LSB,
    parameter int QUIET         = DEF_QUIET
) (
    input  logic           clk,
    input  logic           reset,
    als_spi_ctrl_if.master bus
);
    localparam int CNT_W = cnt_width(CLK_DIV, QUIET);
    localparam int BIT_W = $clog2(NBITS + 1);
    localparam int SH_W  = DATA_LSB + 8;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NBITS);

    als_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bitcnt;
    logic [SH_W-1:0]  shreg;
    logic             pending;
    logic             start_d;
    logic             cs_n_r, sck_r, valid_r, busy_r, overrun_r;
    logic [7:0]       data_r;

    logic tick, start_edge, start_lvl, trig, div_done, quiet_done;
    logic [7:0] raw, result;

    als_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .tick   (tick)
    );

    // A held start is one trigger; its continuation only arms pending, never overrun.
    assign start_edge = bus.start & ~start_d;
    assign start_lvl  = bus.start & start_d;
    assign trig       = tick | start_edge;
    assign div_done   = (cnt == DIV_LAST);
    assign quiet_done = (cnt == QUIET_LAST);
    assign raw        = shreg[DATA_LSB +: 8];

`ifdef ALS_AVG_EN
    logic [2:0][7:0] hist;
    logic [9:0]      sum;
    assign sum    = {2'b00, raw} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    assign result = sum[9:2];
`else
    assign result = raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            pending   <= 1'b0;
            start_d   <= 1'b0;
            cs_n_r    <= 1'b1;
            sck_r     <= 1'b1;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            data_r    <= '0;
`ifdef ALS_AVG_EN
            hist      <= '0;
`endif
        end else begin
            start_d <= bus.start;
            valid_r <= 1'b0;
            cnt     <= cnt + CNT_W'(1);

            if (state != S_IDLE) begin
                if (trig) begin
                    if (pending) overrun_r <= 1'b1;
                    else         pending   <= 1'b1;
                end else if (start_lvl) begin
                    pending <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (trig || pending) begin
                        if (trig && pending) overrun_r <= 1'b1;
                        pending <= 1'b0;
                        cs_n_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: if (div_done) begin
                    cnt    <= '0;
                    sck_r  <= 1'b0;
                    bitcnt <= '0;
                    state  <= S_LOW;
                end
                // Sample on the same edge that raises SCK; the ADC changes SDO on the fall.
                S_LOW: if (div_done) begin
                    cnt    <= '0;
                    sck_r  <= 1'b1;
                    shreg  <= SH_W'({shreg, bus.sdo});
                    bitcnt <= bitcnt + BIT_W'(1);
                    state  <= S_HIGH;
                end
                S_HIGH: if (div_done) begin
                    cnt <= '0;
                    if (bitcnt == BIT_LAST) begin
                        state <= S_TAIL;
                    end else begin
                        sck_r <= 1'b0;
                        state <= S_LOW;
                    end
                end
                S_TAIL: if (div_done) begin
                    cnt     <= '0;
                    cs_n_r  <= 1'b1;
                    data_r  <= result;
                    valid_r <= 1'b1;
`ifdef ALS_AVG_EN
                    hist    <= {hist[1:0], raw};
`endif
                    state   <= S_QUIET;
                end
                S_QUIET: if (quiet_done) begin
                    cnt    <= '0;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cs_n       = cs_n_r;
    assign bus.sck        = sck_r;
    assign bus.data       = data_r;
    assign bus.data_valid = valid_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_als_spi_ctrl.sv
// Scoreboard bench for als_spi_ctrl: random frames, periodic trigger, pending/overrun, mid-frame reset.
module tb_als_spi_ctrl;
    import als_pkg::*;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 500;
    localparam int NBITS         = 16;
    localparam int DATA_LSB      = 4;
    localparam int QUIET         = 24;
    // Edges from the accepting edge to the edge that raises data_valid.
    localparam int LAT           = CLK_DIV * (2 * NBITS + 2);

    logic clk = 1'b0;
    logic reset = 1'b1;
    als_spi_ctrl_if bus();

    als_spi_ctrl #(
        .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD), .NBITS(NBITS),
        .DATA_LSB(DATA_LSB), .QUIET(QUIET)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] val;
        int         at;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] word_q[$];
    logic [7:0]  hist[$];
    logic [7:0]  held;
    int          rises;
    logic        prev_sck, prev_cs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: value field of the frame, optionally averaged over the last four captures.
    function automatic logic [7:0] model(input logic [15:0] w);
        logic [7:0] r;
        r = 8'((w >> DATA_LSB) & 16'hFF);
`ifdef ALS_AVG_EN
        begin
            int s;
            hist.push_front(r);
            if (hist.size() > 4) void'(hist.pop_back());
            s = 0;
            foreach (hist[i]) s += int'(hist[i]);
            return 8'(s / 4);
        end
`else
        return r;
`endif
    endfunction

    task automatic push_frame(input logic [15:0] w, input int trig_edge);
        exp_t e;
        word_q.push_back(w);
        e.val = model(w);
        e.at  = trig_edge + LAT;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < max) begin
            step();
            n++;
        end
        checks++;
        if (n >= max) begin
            failures++;
            $display("FAIL %s: timeout after %0d cycles, %0d frames outstanding", name, n, exp_q.size());
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        hist.delete();
    endtask

    // ADC model: presents the next frame bit MSB-first on each SCK fall.
    int          bi;
    logic [15:0] cur_w;
    always @(negedge bus.cs_n) begin
        bi    = NBITS - 1;
        cur_w = (word_q.size() != 0) ? word_q.pop_front() : 16'h0000;
    end
    always @(negedge bus.sck) begin
        if (!bus.cs_n && bi >= 0) begin
            bus.sdo = cur_w[bi];
            bi--;
        end
    end

    // Monitor: pops the scoreboard on every valid strobe and watches pin behaviour.
    always @(negedge clk) begin
        if (reset) begin
            held     = 8'h00;
            rises    = 0;
            prev_sck = 1'b1;
            prev_cs  = 1'b1;
        end else begin
            if (bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: data %0h at cycle %0d, none expected", bus.data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data", bus.data, e.val);
                    chk("valid_cycle", cyc, e.at);
                    held = e.val;
                end
            end else begin
                chk("data_hold", bus.data, held);
            end
            if (bus.cs_n) chk("sck_idle_high", bus.sck, 1);
            if (bus.sck && !prev_sck) rises++;
            if (bus.cs_n && !prev_cs) begin
                chk("sck_rises", rises, NBITS);
                rises = 0;
            end
            prev_sck = bus.sck;
            prev_cs  = bus.cs_n;
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int k, r, n;
        logic ps;
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        bus.sdo    = 1'b0;
        reset      = 1'b1;
        step(3);
        reset = 1'b0;

        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_sck", bus.sck, 1);
        chk("rst_data", bus.data, 0);
        chk("rst_valid", bus.data_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        step(1000);
        chk("idle_rises", rises, 0);
        chk("idle_cs_n", bus.cs_n, 1);

        // Known frame.
        push_frame(16'h0A5F, cyc + 1);
        pulse_start();
        drain("single", 300);
`ifndef ALS_AVG_EN
        chk("single_data", bus.data, 8'hA5);
`endif
        chk("single_cs_n_after", bus.cs_n, 1);

        // Random isolated frames.
        for (int i = 0; i < 6; i++) begin
            step($urandom_range(0, 30));
            push_frame(16'($urandom), cyc + 1);
            pulse_start();
            drain("random_single", 300);
        end

        // Periodic trigger: first tick SAMPLE_PERIOD clocks after enable.
        step(5);
        k = cyc;
        for (int i = 1; i <= 5; i++) push_frame(16'($urandom), k + SAMPLE_PERIOD * i);
        bus.enable = 1'b1;
        drain("periodic", 3000);
        bus.enable = 1'b0;
        chk("periodic_overrun", bus.overrun, 0);

        // Pending and overrun: three start pulses 10 clocks apart, two frames.
        step(10);
        k = cyc;
        push_frame(16'($urandom), k + 1);
        push_frame(16'($urandom), k + 1 + LAT + QUIET + 1);
        pulse_start();
        step(9);
        pulse_start();
        step(9);
        pulse_start();
        drain("pending", 600);
        chk("overrun_set", bus.overrun, 1);
        do_reset();
        chk("overrun_cleared", bus.overrun, 0);

        // Start held for four clocks: one frame plus one pending, no overrun.
        step(5);
        k = cyc;
        push_frame(16'($urandom), k + 1);
        push_frame(16'($urandom), k + 1 + LAT + QUIET + 1);
        bus.start = 1'b1;
        step(4);
        bus.start = 1'b0;
        drain("held_start", 600);
        chk("held_overrun", bus.overrun, 0);

        // Reset after the 7th SCK rise aborts the frame silently.
        step(5);
        word_q.push_back(16'($urandom));
        pulse_start();
        r  = 0;
        n  = 0;
        ps = bus.sck;
        while (r < 7 && n < 200) begin
            step();
            n++;
            if (bus.sck && !ps) r++;
            ps = bus.sck;
        end
        chk("abort_rises_seen", r, 7);
        reset = 1'b1;
        step();
        chk("abort_cs_n", bus.cs_n, 1);
        chk("abort_sck", bus.sck, 1);
        chk("abort_valid", bus.data_valid, 0);
        chk("abort_busy", bus.busy, 0);
        reset = 1'b0;
        hist.delete();
        step(40);
        push_frame(16'($urandom), cyc + 1);
        pulse_start();
        drain("after_abort", 300);
        chk("final_queue_empty", exp_q.size(), 0);

        step(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
